// File: rtl/mem_ctrl_mc_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_mc_pkg
// Shared definitions for the multi-channel byte-bus memory controller:
// controller state encoding, bus direction constants, zero constants and the
// default parameter values used by mem_ctrl_mc and mem_arb.
// -----------------------------------------------------------------------------
package mem_ctrl_mc_pkg;

  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_BYTES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam logic MEM_R = 1'b0;
  localparam logic MEM_W = 1'b1;

  localparam logic [7:0]  ZERO_BYTE = 8'h00;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/mem_ctrl_mc_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
// Picks one requester out of the eligible vector.
//   MEM_RR_ARB_EN undefined : fixed priority, lowest eligible index wins.
//   MEM_RR_ARB_EN defined   : round-robin, search starts one past the last
//                             granted channel; pointer advances on take_in.
// Ports:
//   clk_in, rst_n_in  clock / async active-low reset (round-robin build only)
//   take_in           grant is being accepted this edge (round-robin only)
//   elig_in           per-channel eligible requests
//   gnt_out           one-hot grant
//   valid_out         at least one channel is eligible
// -----------------------------------------------------------------------------
module mem_arb
  import mem_ctrl_mc_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
`ifdef MEM_RR_ARB_EN
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              take_in,
`endif
  input  logic [NUM_CH-1:0] elig_in,
  output logic [NUM_CH-1:0] gnt_out,
  output logic              valid_out
);

  assign valid_out = |elig_in;

`ifdef MEM_RR_ARB_EN
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] last_q, last_d;

  // Rotate the search origin so the channel after the last winner is asked
  // first; the pointer only moves when the grant is actually taken.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    gnt_out = '0;
    last_d  = last_q;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(last_q) + 1 + i) % NUM_CH;
      if (elig_in[idx] && !found) begin
        gnt_out[idx] = 1'b1;
        found        = 1'b1;
        if (take_in) last_d = PTR_W'(idx);
      end
    end
  end

  // Pointer starts at the top channel so channel 0 is asked first after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) last_q <= PTR_W'(NUM_CH - 1);
    else           last_q <= last_d;
  end
`else
  always_comb begin
    logic found;
    found   = 1'b0;
    gnt_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (elig_in[i] && !found) begin
        gnt_out[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_ctrl_mc.sv
// -----------------------------------------------------------------------------
// mem_ctrl_mc
// Arbitrates NUM_CH load/store/fetch requesters onto one 8-bit RAM/IO bus.
// Each transfer moves 1..DATA_BYTES bytes little-endian, one byte per cycle.
// Build option: define MEM_RR_ARB_EN for round-robin arbitration, otherwise
// fixed priority (channel 0 highest).
// Ports:
//   clk_in, rst_n_in   clock / async active-low reset
//   rdy_in             global enable; low freezes all state and blocks mem_wr
//   flush_in           aborts the in-flight transfer, no done pulse
//   req_in/wr_in       per-channel request level / direction (1 = write)
//   addr_in/len_in     per-channel start address / byte count (packed slices)
//   wdata_in           per-channel store data, byte 0 in the LSBs
//   rdata_out          load result, zero above the transfer length
//   done_out           one-hot single-cycle completion pulse
//   mem_din/mem_dout   RAM read byte (one cycle behind mem_a) / write byte
//   mem_a/mem_wr       byte address / write strobe
// -----------------------------------------------------------------------------
module mem_ctrl_mc
  import mem_ctrl_mc_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int LEN_W      = $clog2(DATA_BYTES) + 1
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic [NUM_CH-1:0]              req_in,
  input  logic [NUM_CH-1:0]              wr_in,
  input  logic [NUM_CH*ADDR_W-1:0]       addr_in,
  input  logic [NUM_CH*LEN_W-1:0]        len_in,
  input  logic [NUM_CH*8*DATA_BYTES-1:0] wdata_in,
  output logic [8*DATA_BYTES-1:0]        rdata_out,
  output logic [NUM_CH-1:0]              done_out,
  input  logic [7:0]                     mem_din,
  output logic [7:0]                     mem_dout,
  output logic [ADDR_W-1:0]              mem_a,
  output logic                           mem_wr
);

  localparam int                CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                DW      = 8 * DATA_BYTES;
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(DATA_BYTES);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               dir_q, dir_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      buf_q, buf_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [ADDR_W-1:0]  mem_a_q, mem_a_d;
  logic [7:0]         mem_dout_q, mem_dout_d;

  logic [NUM_CH-1:0]  elig, gnt;
  logic               gnt_valid, start;
  logic [CH_W-1:0]    gnt_idx;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len_raw, sel_len;
  logic [DW-1:0]      sel_wdata;

  // A channel whose done pulse is showing is masked so it is not regranted
  // before its requester has had a chance to drop req.
  assign elig    = req_in & ~done_q;
  assign start   = (state_q == IDLE) && gnt_valid && !flush_in;
  assign cnt_nxt = cnt_q + LEN_W'(1);

`ifdef MEM_RR_ARB_EN
  logic take;
  assign take = rdy_in && start;
`endif

  mem_arb #(.NUM_CH(NUM_CH)) u_arb (
`ifdef MEM_RR_ARB_EN
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .take_in   (take),
`endif
    .elig_in   (elig),
    .gnt_out   (gnt),
    .valid_out (gnt_valid)
  );

  // Mux the winning channel's request fields out of the packed input slices.
  always_comb begin
    gnt_idx     = '0;
    sel_wr      = MEM_R;
    sel_addr    = '0;
    sel_len_raw = '0;
    sel_wdata   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) begin
        gnt_idx     = CH_W'(c);
        sel_wr      = wr_in[c];
        sel_addr    = addr_in[c*ADDR_W +: ADDR_W];
        sel_len_raw = len_in[c*LEN_W +: LEN_W];
        sel_wdata   = wdata_in[c*DW +: DW];
      end
    end
    sel_len = (sel_len_raw > MAX_LEN) ? MAX_LEN : sel_len_raw;
  end

  // Transfer sequencing. cnt_q counts enabled edges since the accept edge.
  // Reads: the byte for the address of cycle k arrives on mem_din one cycle
  // later, so byte cnt-1 is captured on each edge and the last byte is folded
  // straight into rdata on the completing edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    dir_d      = dir_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    done_d     = done_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    if (rdy_in) begin
      done_d = '0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = XFER;
            cnt_d   = '0;
            ch_d    = gnt_idx;
            dir_d   = sel_wr;
            addr_d  = sel_addr;
            len_d   = sel_len;
            wdata_d = sel_wdata;
            // A zero-length transfer never touches the bus.
            if (sel_len != '0) begin
              mem_a_d = sel_addr;
              if (sel_wr == MEM_W) begin
                wr_d       = 1'b1;
                mem_dout_d = sel_wdata[7:0];
              end
            end
          end
        end
        XFER: begin
          if (flush_in || !req_in[ch_q]) begin
            // Abort wins over completion; bytes already written stay written.
            state_d = IDLE;
            wr_d    = 1'b0;
            mem_a_d = '0;
          end else if (dir_q == MEM_W) begin
            if (cnt_nxt >= len_q) begin
              done_d[ch_q] = 1'b1;
              state_d      = IDLE;
              wr_d         = 1'b0;
              mem_a_d      = '0;
            end else begin
              cnt_d   = cnt_nxt;
              mem_a_d = addr_q + ADDR_W'(cnt_nxt);
              for (int i = 0; i < DATA_BYTES; i++) begin
                if (LEN_W'(i) == cnt_nxt) mem_dout_d = wdata_q[i*8 +: 8];
              end
            end
          end else begin
            for (int i = 0; i < DATA_BYTES; i++) begin
              if (cnt_q != '0 && (cnt_q - LEN_W'(1)) == LEN_W'(i))
                buf_d[i*8 +: 8] = mem_din;
            end
            if (cnt_q == len_q) begin
              for (int i = 0; i < DATA_BYTES; i++) begin
                rdata_d[i*8 +: 8] = (LEN_W'(i) < len_q) ? buf_d[i*8 +: 8] : ZERO_BYTE;
              end
              done_d[ch_q] = 1'b1;
              state_d      = IDLE;
              mem_a_d      = '0;
            end else begin
              cnt_d = cnt_nxt;
              if (cnt_nxt < len_q) mem_a_d = addr_q + ADDR_W'(cnt_nxt);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; reset is asynchronous so it clears a transfer mid-flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      dir_q      <= MEM_R;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= ZERO_BYTE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      dir_q      <= dir_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
    end
  end

  // The write strobe is gated by rdy_in so a stalled write byte is only
  // committed once the bus is enabled again.
  assign mem_wr    = wr_q & rdy_in;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign rdata_out = rdata_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_mem_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_mc
// Directed bench for mem_ctrl_mc with a byte RAM model whose read data lags
// the address by one cycle. The RAM model follows the global enable rdy_in.
// -----------------------------------------------------------------------------
module tb_mem_ctrl_mc;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_BYTES = 4;
  localparam int LEN_W = 3;

  logic clk = 1'b0;
  logic rst_n, rdy, flush;
  logic [NUM_CH-1:0] req, wr;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*LEN_W-1:0] len;
  logic [NUM_CH*8*DATA_BYTES-1:0] wdata;
  logic [8*DATA_BYTES-1:0] rdata;
  logic [NUM_CH-1:0] done;
  logic [7:0] mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic mem_wr;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:4095];

  always #5 clk = ~clk;

  mem_ctrl_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .LEN_W(LEN_W)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .req_in(req), .wr_in(wr), .addr_in(addr), .len_in(len), .wdata_in(wdata),
    .rdata_out(rdata), .done_out(done), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // Synchronous RAM: returns the byte of the previous cycle's address.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) ram[mem_a[11:0]] = mem_dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ch(input int c, input logic w, input logic [31:0] a,
                          input logic [2:0] l, input logic [31:0] d);
    wr[c] = w;
    addr[c*32 +: 32] = a;
    len[c*3 +: 3] = l;
    wdata[c*32 +: 32] = d;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3;
    checks++; if (mem_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_a got %h exp %h", mem_a, 32'h0); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("[TB] FAIL reset_mem_dout got %h exp %h", mem_dout, 8'h0); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_wr got %b exp 0", mem_wr); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h exp %h", rdata, 32'h0); end
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL reset_done got %b exp 00", done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read4();
    drive_ch(0, 1'b0, 32'h100, 3'd4, 32'h0);
    req[0] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem_a !== 32'h100 + k) begin errors++; $display("[TB] FAIL rd4_addr%0d got %h exp %h", k, mem_a, 32'h100 + k); end
      checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL rd4_early_done%0d got %b exp 00", k, done); end
      tick();
    end
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL rd4_done_e4 got %b exp 00", done); end
    tick();
    checks++; if (done !== 2'b01) begin errors++; $display("[TB] FAIL rd4_done got %b exp 01", done); end
    checks++; if (rdata !== 32'h44332211) begin errors++; $display("[TB] FAIL rd4_rdata got %h exp %h", rdata, 32'h44332211); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("[TB] FAIL rd4_addr_idle got %h exp 0", mem_a); end
    req[0] = 1'b0;
    tick();
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL rd4_done_pulse got %b exp 00", done); end
    checks++; if (rdata !== 32'h44332211) begin errors++; $display("[TB] FAIL rd4_rdata_hold got %h exp %h", rdata, 32'h44332211); end
  endtask

  task automatic test_write2();
    drive_ch(1, 1'b1, 32'h200, 3'd2, 32'hAABBCCDD);
    req[1] = 1'b1;
    tick();
    checks++; if (mem_a !== 32'h200) begin errors++; $display("[TB] FAIL wr2_addr0 got %h exp %h", mem_a, 32'h200); end
    checks++; if (mem_dout !== 8'hDD) begin errors++; $display("[TB] FAIL wr2_dout0 got %h exp DD", mem_dout); end
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL wr2_wr0 got %b exp 1", mem_wr); end
    tick();
    checks++; if (mem_a !== 32'h201) begin errors++; $display("[TB] FAIL wr2_addr1 got %h exp %h", mem_a, 32'h201); end
    checks++; if (mem_dout !== 8'hCC) begin errors++; $display("[TB] FAIL wr2_dout1 got %h exp CC", mem_dout); end
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL wr2_wr1 got %b exp 1", mem_wr); end
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL wr2_early_done got %b exp 00", done); end
    tick();
    checks++; if (done !== 2'b10) begin errors++; $display("[TB] FAIL wr2_done got %b exp 10", done); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL wr2_wr_end got %b exp 0", mem_wr); end
    req[1] = 1'b0;
    checks++; if (ram[12'h200] !== 8'hDD) begin errors++; $display("[TB] FAIL wr2_ram200 got %h exp DD", ram[12'h200]); end
    checks++; if (ram[12'h201] !== 8'hCC) begin errors++; $display("[TB] FAIL wr2_ram201 got %h exp CC", ram[12'h201]); end
    checks++; if (ram[12'h202] !== 8'h5A) begin errors++; $display("[TB] FAIL wr2_ram202 got %h exp 5A", ram[12'h202]); end
    tick();
  endtask

  task automatic test_arbitration();
    int exp_ch;
    for (int r = 0; r < 4; r++) begin
      drive_ch(0, 1'b0, 32'h100, 3'd1, 32'h0);
      drive_ch(1, 1'b0, 32'h101, 3'd1, 32'h0);
      req = 2'b11;
`ifdef MEM_RR_ARB_EN
      exp_ch = r % 2;
`else
      exp_ch = 0;
`endif
      tick();
      checks++; if (mem_a !== 32'h100 + exp_ch) begin errors++; $display("[TB] FAIL arb_r%0d_addr got %h exp %h", r, mem_a, 32'h100 + exp_ch); end
      tick();
      tick();
      checks++; if (done !== (exp_ch == 1 ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL arb_r%0d_done got %b exp ch%0d", r, done, exp_ch); end
      checks++; if (rdata !== (exp_ch == 1 ? 32'h22 : 32'h11)) begin errors++; $display("[TB] FAIL arb_r%0d_rdata got %h", r, rdata); end
      req = 2'b00;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    drive_ch(0, 1'b0, 32'h102, 3'd1, 32'h0);
    drive_ch(1, 1'b0, 32'h103, 3'd1, 32'h0);
    req = 2'b11;
    tick();
    checks++; if (mem_a !== 32'h102) begin errors++; $display("[TB] FAIL b2b_addr0 got %h exp %h", mem_a, 32'h102); end
    tick();
    tick();
    checks++; if (done !== 2'b01) begin errors++; $display("[TB] FAIL b2b_done0 got %b exp 01", done); end
    checks++; if (rdata !== 32'h33) begin errors++; $display("[TB] FAIL b2b_rdata0 got %h exp 33", rdata); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("[TB] FAIL b2b_idle_gap got %h exp 0", mem_a); end
    req[0] = 1'b0;
    tick();
    checks++; if (mem_a !== 32'h103) begin errors++; $display("[TB] FAIL b2b_addr1 got %h exp %h", mem_a, 32'h103); end
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL b2b_done_clear got %b exp 00", done); end
    tick();
    tick();
    checks++; if (done !== 2'b10) begin errors++; $display("[TB] FAIL b2b_done1 got %b exp 10", done); end
    checks++; if (rdata !== 32'h44) begin errors++; $display("[TB] FAIL b2b_rdata1 got %h exp 44", rdata); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_stall_read();
    drive_ch(0, 1'b0, 32'h100, 3'd4, 32'h0);
    req[0] = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (mem_a !== 32'h102) begin errors++; $display("[TB] FAIL stall_addr_pre got %h exp %h", mem_a, 32'h102); end
    rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (mem_a !== 32'h102) begin errors++; $display("[TB] FAIL stall_addr_hold%0d got %h exp %h", s, mem_a, 32'h102); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL stall_wr%0d got %b exp 0", s, mem_wr); end
      checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL stall_done%0d got %b exp 00", s, done); end
    end
    rdy = 1'b1;
    tick();
    checks++; if (mem_a !== 32'h103) begin errors++; $display("[TB] FAIL stall_addr_post got %h exp %h", mem_a, 32'h103); end
    tick();
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL stall_early_done got %b exp 00", done); end
    tick();
    checks++; if (done !== 2'b01) begin errors++; $display("[TB] FAIL stall_done got %b exp 01", done); end
    checks++; if (rdata !== 32'h44332211) begin errors++; $display("[TB] FAIL stall_rdata got %h exp %h", rdata, 32'h44332211); end
    req[0] = 1'b0;
    tick();
  endtask

  task automatic test_stall_write();
    drive_ch(1, 1'b1, 32'h210, 3'd2, 32'h00006655);
    req[1] = 1'b1;
    tick();
    rdy = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL stwr_wr_gated got %b exp 0", mem_wr); end
    tick();
    checks++; if (ram[12'h210] !== 8'h5A) begin errors++; $display("[TB] FAIL stwr_ram_untouched got %h exp 5A", ram[12'h210]); end
    checks++; if (mem_dout !== 8'h55) begin errors++; $display("[TB] FAIL stwr_dout_hold got %h exp 55", mem_dout); end
    checks++; if (mem_a !== 32'h210) begin errors++; $display("[TB] FAIL stwr_addr_hold got %h exp %h", mem_a, 32'h210); end
    rdy = 1'b1;
    #1;
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL stwr_wr_resume got %b exp 1", mem_wr); end
    tick();
    checks++; if (ram[12'h210] !== 8'h55) begin errors++; $display("[TB] FAIL stwr_ram210 got %h exp 55", ram[12'h210]); end
    checks++; if (mem_dout !== 8'h66) begin errors++; $display("[TB] FAIL stwr_dout1 got %h exp 66", mem_dout); end
    tick();
    checks++; if (done !== 2'b10) begin errors++; $display("[TB] FAIL stwr_done got %b exp 10", done); end
    checks++; if (ram[12'h211] !== 8'h66) begin errors++; $display("[TB] FAIL stwr_ram211 got %h exp 66", ram[12'h211]); end
    req[1] = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    drive_ch(0, 1'b1, 32'h208, 3'd4, 32'h04030201);
    drive_ch(1, 1'b0, 32'h100, 3'd1, 32'h0);
    req = 2'b11;
    tick();
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL flush_wr0 got %b exp 1", mem_wr); end
    checks++; if (mem_dout !== 8'h01) begin errors++; $display("[TB] FAIL flush_dout0 got %h exp 01", mem_dout); end
    flush = 1'b1;
    tick();
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL flush_wr_off got %b exp 0", mem_wr); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("[TB] FAIL flush_addr got %h exp 0", mem_a); end
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL flush_no_done got %b exp 00", done); end
    checks++; if (ram[12'h208] !== 8'h01) begin errors++; $display("[TB] FAIL flush_ram208 got %h exp 01", ram[12'h208]); end
    flush = 1'b0;
    req[0] = 1'b0;
    tick();
    checks++; if (mem_a !== 32'h100) begin errors++; $display("[TB] FAIL flush_next_grant got %h exp %h", mem_a, 32'h100); end
    checks++; if (ram[12'h209] !== 8'h5A) begin errors++; $display("[TB] FAIL flush_ram209 got %h exp 5A", ram[12'h209]); end
    tick();
    tick();
    checks++; if (done !== 2'b10) begin errors++; $display("[TB] FAIL flush_ch1_done got %b exp 10", done); end
    checks++; if (rdata !== 32'h11) begin errors++; $display("[TB] FAIL flush_ch1_rdata got %h exp 11", rdata); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_clamp_wrap();
    drive_ch(0, 1'b0, 32'h100, 3'd7, 32'h0);
    req[0] = 1'b1;
    repeat (5) tick();
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL clamp_early_done got %b exp 00", done); end
    tick();
    checks++; if (done !== 2'b01) begin errors++; $display("[TB] FAIL clamp_done got %b exp 01", done); end
    checks++; if (rdata !== 32'h44332211) begin errors++; $display("[TB] FAIL clamp_rdata got %h exp %h", rdata, 32'h44332211); end
    req[0] = 1'b0;
    tick();
    drive_ch(0, 1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0);
    req[0] = 1'b1;
    tick();
    checks++; if (mem_a !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wrap_addr0 got %h exp FFFFFFFF", mem_a); end
    tick();
    checks++; if (mem_a !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr1 got %h exp 0", mem_a); end
    tick();
    tick();
    checks++; if (done !== 2'b01) begin errors++; $display("[TB] FAIL wrap_done got %b exp 01", done); end
    checks++; if (rdata !== 32'h8877) begin errors++; $display("[TB] FAIL wrap_rdata got %h exp 8877", rdata); end
    req[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    drive_ch(1, 1'b1, 32'h218, 3'd4, 32'hDEADBEEF);
    req[1] = 1'b1;
    tick();
    tick();
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre_wr got %b exp 1", mem_wr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_a !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_addr got %h exp 0", mem_a); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("[TB] FAIL rstmid_dout got %h exp 0", mem_dout); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_wr got %b exp 0", mem_wr); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_rdata got %h exp 0", rdata); end
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_done got %b exp 00", done); end
    tick();
    req[1] = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    drive_ch(0, 1'b0, 32'h100, 3'd0, 32'h0);
    req[0] = 1'b1;
    tick();
    checks++; if (mem_a !== 32'h0) begin errors++; $display("[TB] FAIL len0_no_bus got %h exp 0", mem_a); end
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL len0_early_done got %b exp 00", done); end
    tick();
    checks++; if (done !== 2'b01) begin errors++; $display("[TB] FAIL len0_done got %b exp 01", done); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL len0_rdata got %h exp 0", rdata); end
    req[0] = 1'b0;
    tick();
    checks++; if (done !== 2'b00) begin errors++; $display("[TB] FAIL len0_pulse got %b exp 00", done); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    for (int i = 12'h200; i < 12'h220; i++) ram[i] = 8'h5A;
    ram[12'hFFF] = 8'h77;
    ram[12'h000] = 8'h88;
    rst_n = 1'b0;
    rdy = 1'b1;
    flush = 1'b0;
    req = '0;
    wr = '0;
    addr = '0;
    len = '0;
    wdata = '0;
    test_reset();
    test_read4();
    test_write2();
    test_arbitration();
    test_back_to_back();
    test_stall_read();
    test_stall_write();
    test_flush();
    test_clamp_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
